// File: rtl/systolic_sched.sv
// Sequencer for one output-stationary matmul pass over an N x N PE grid.
// Define SYS_SCHED_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles.
module systolic_sched #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned KW = 8
`ifdef SYS_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 256
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            op_rd_en,
  output logic [KW-1:0]   op_rd_addr,
  input  logic [N*DW-1:0] a_rd_data,
  input  logic [N*DW-1:0] b_rd_data,
  output logic [N*DW-1:0] arr_a,
  output logic [N*DW-1:0] arr_b,
  output logic [N-1:0]    arr_valid,
  output logic            arr_clear,
  input  logic [N*N-1:0]  pe_valid_out,
  input  logic [N*N-1:0]  pe_overflow,
  output logic            err_overflow,
  output logic            err_timeout
);

  localparam int unsigned FCW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_WAIT, S_DONE
  } state_e;

  state_e         state_q;
  logic [KW-1:0]  k_len_q;
  logic           busy_q, done_q, rd_en_q, clear_q, err_ov_q;
  logic [KW-1:0]  rd_addr_q;
  logic [N*N-1:0] seen_q;
  logic [N*N-1:0] seen_d;
  logic [FCW-1:0] flush_cnt_q;
  logic [N-1:0]   vld_q;
  logic           wait_expired;

  assign seen_d = seen_q | pe_valid_out;

  // Pass sequencing; outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      clear_q     <= 1'b0;
      seen_q      <= '0;
      flush_cnt_q <= '0;
      err_ov_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      if (state_q != S_IDLE) err_ov_q <= err_ov_q | (|pe_overflow);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            k_len_q  <= k_len;
            busy_q   <= 1'b1;
            err_ov_q <= 1'b0;
            if (k_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CLEAR;
              clear_q <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          state_q   <= S_FEED;
          seen_q    <= '0;
          rd_en_q   <= 1'b1;
          rd_addr_q <= '0;
        end
        S_FEED: begin
          seen_q <= seen_d;
          if (rd_addr_q == k_len_q - KW'(1)) begin
            state_q     <= S_FLUSH;
            rd_en_q     <= 1'b0;
            flush_cnt_q <= '0;
          end else begin
            rd_addr_q <= rd_addr_q + KW'(1);
          end
        end
        S_FLUSH: begin
          seen_q <= seen_d;
          if (flush_cnt_q == FCW'(N - 1)) state_q <= S_WAIT;
          else flush_cnt_q <= flush_cnt_q + FCW'(1);
        end
        S_WAIT: begin
          seen_q <= seen_d;
          if ((&seen_d) || wait_expired) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SYS_SCHED_TIMEOUT_EN
  localparam int unsigned WCW = $clog2(TIMEOUT + 1);
  logic [WCW-1:0] wait_cnt_q;
  logic           err_to_q;

  assign wait_expired = (state_q == S_WAIT) && !(&seen_d) &&
                        (wait_cnt_q == WCW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      err_to_q   <= 1'b0;
    end else begin
      if (state_q != S_WAIT) wait_cnt_q <= '0;
      else wait_cnt_q <= wait_cnt_q + WCW'(1);
      if (state_q == S_IDLE && start) err_to_q <= 1'b0;
      else if (wait_expired) err_to_q <= 1'b1;
    end
  end

  assign err_timeout = err_to_q;
`else
  assign wait_expired = 1'b0;
  assign err_timeout  = 1'b0;
`endif

  // vld_q[i] is the read strobe delayed 1+i cycles; bit 0 marks valid buffer data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_en_q;
      for (int i = 1; i < N; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Lane i runs through i stages; invalid cycles shift in zeros.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_in, b_in;
    assign a_in = vld_q[0] ? a_rd_data[i*DW +: DW] : '0;
    assign b_in = vld_q[0] ? b_rd_data[i*DW +: DW] : '0;
    if (i == 0) begin : g_direct
      assign arr_a[DW-1:0] = a_in;
      assign arr_b[DW-1:0] = b_in;
    end else begin : g_skew
      logic [DW-1:0] a_sr_q [0:i-1];
      logic [DW-1:0] b_sr_q [0:i-1];
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int s = 0; s < i; s++) begin
            a_sr_q[s] <= '0;
            b_sr_q[s] <= '0;
          end
        end else begin
          a_sr_q[0] <= a_in;
          b_sr_q[0] <= b_in;
          for (int s = 1; s < i; s++) begin
            a_sr_q[s] <= a_sr_q[s-1];
            b_sr_q[s] <= b_sr_q[s-1];
          end
        end
      end
      assign arr_a[i*DW +: DW] = a_sr_q[i-1];
      assign arr_b[i*DW +: DW] = b_sr_q[i-1];
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign op_rd_en     = rd_en_q;
  assign op_rd_addr   = rd_addr_q;
  assign arr_valid    = vld_q;
  assign arr_clear    = clear_q;
  assign err_overflow = err_ov_q;

endmodule
